// File: rtl/rv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : rv_lsu
// Description : Load/store unit; one req/ack data-memory access per start,
//               with lane steering, load extension and fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [XLEN-1:0] rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_cnt;
  logic            r_we;
  logic            r_fault;
  logic [2:0]      r_f3;
  logic [1:0]      r_lane;

  logic            w_legal;
  logic            w_aligned;
  logic            w_ok;
  logic            w_accept;
  logic            w_timeout;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;

  // LBU/LHU exist only as loads; sizes 011 and above are otherwise illegal.
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~we;
      default:                w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   w_aligned = ~addr[0];
      2'b10:   w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  assign w_ok      = w_legal & w_aligned;
  assign w_accept  = (r_state == ST_IDLE) & start;
  assign w_timeout = (r_cnt == C_TMO_LAST);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {(XLEN/8){wdata[7:0]}};
      end
      2'b01: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {(XLEN/16){wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata;
      end
    endcase
  end

  assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load = mem_rdata;
    case (r_f3)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = w_ok ? ST_REQ : ST_RESP;
      ST_REQ:  if (mem_ack || w_timeout) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_we      <= 1'b0;
      r_fault   <= 1'b0;
      r_f3      <= 3'b000;
      r_lane    <= 2'b00;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      r_state <= w_next;
      mem_req <= (w_next == ST_REQ);
      mem_we  <= (w_next == ST_REQ) & (w_accept ? we : mem_we);

      // Memory-side fields only load at acceptance, so they stay stable for the whole request.
      if (w_accept) begin
        r_we      <= we;
        r_f3      <= funct3;
        r_lane    <= addr[1:0];
        r_fault   <= ~w_ok;
        r_cnt     <= 8'd0;
        mem_addr  <= {addr[XLEN-1:2], 2'b00};
        mem_be    <= w_be;
        mem_wdata <= w_wdata;
        if (!w_ok) rdata <= '0;
      end else if (r_state == ST_REQ) begin
        if (mem_ack) begin
          if (!r_we) rdata <= w_load;
        end else begin
          r_cnt <= r_cnt + 8'd1;
          if (w_timeout) begin
            r_fault <= 1'b1;
            rdata   <= '0;
          end
        end
      end
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign done  = (r_state == ST_RESP);
  assign fault = done & r_fault;

endmodule
`default_nettype wire

// File: tb/tb_rv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_lsu
// Description : Scoreboard bench for rv_lsu with a scripted memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  rv_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .we       (we),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .rdata    (rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } dexp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          len;
  } mexp_t;

  dexp_t dq[$];
  mexp_t mq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // memory responder controls
  int          ack_dly  = -1;
  logic [31:0] mem_val  = 32'h0;
  logic        late_ack = 1'b0;
  int          k        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @cyc %0d", nm, act, exp, cyc);
    end
  endtask

  // memory responder: acks in the ack_dly-th request cycle
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_ack   = (k == ack_dly);
        mem_rdata = mem_val;
        k++;
      end else begin
        mem_ack = late_ack;
        k       = 0;
      end
    end
  end

  // completion monitor
  initial begin
    dexp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = dq.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("fault", {31'd0, fault}, {31'd0, e.fault});
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // memory-request monitor
  initial begin
    mexp_t m;
    logic  in_burst = 1'b0;
    logic  have     = 1'b0;
    int    blen     = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          blen     = 0;
          have     = (mq.size() != 0);
          if (have) m = mq.pop_front();
          else chk("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
        end
        blen++;
        if (have) begin
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
          chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end else if (in_burst) begin
        in_burst = 1'b0;
        if (have) chk("mem_req_len", blen, m.len);
      end
    end
  end

  task automatic issue(input logic iwe, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int dly, input logic [31:0] rv,
                       input logic [31:0] erd, input logic ef, input int lat,
                       input logic hasmem, input logic [3:0] ebe,
                       input logic [31:0] ewd, input int len);
    dexp_t d;
    mexp_t m;
    @(negedge clk);
    start   = 1'b1;
    we      = iwe;
    funct3  = f3;
    addr    = a;
    wdata   = wd;
    ack_dly = dly;
    mem_val = rv;
    d.rdata = erd;
    d.fault = ef;
    d.cyc   = cyc + lat;
    dq.push_back(d);
    if (hasmem) begin
      m.addr  = {a[31:2], 2'b00};
      m.be    = ebe;
      m.wdata = ewd;
      m.we    = iwe;
      m.len   = len;
      mq.push_back(m);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((dq.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL wait_done timeout pending=%0d busy=%0b", dq.size(), busy);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    we     = 1'b0;
    funct3 = 3'b000;
    addr   = 32'h0;
    wdata  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // loads: lane extraction and extension
    issue(0, 3'b010, 32'h100, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 0, 4, 1, 4'b1111, 0, 3);
    wait_done();
    issue(0, 3'b000, 32'h103, 0, 1, 32'h80123456, 32'hFFFFFF80, 0, 3, 1, 4'b1000, 0, 2);
    wait_done();
    issue(0, 3'b100, 32'h103, 0, 1, 32'h80123456, 32'h00000080, 0, 3, 1, 4'b1000, 0, 2);
    wait_done();
    issue(0, 3'b101, 32'h102, 0, 1, 32'h80123456, 32'h00008012, 0, 3, 1, 4'b1100, 0, 2);
    wait_done();
    issue(0, 3'b001, 32'h102, 0, 1, 32'h80123456, 32'hFFFF8012, 0, 3, 1, 4'b1100, 0, 2);
    wait_done();
    issue(0, 3'b000, 32'h101, 0, 0, 32'h80123456, 32'h00000034, 0, 2, 1, 4'b0010, 0, 1);
    wait_done();

    // stores leave rdata untouched
    issue(1, 3'b001, 32'h22, 32'h1234ABCD, 0, 0, 32'h00000034, 0, 2, 1, 4'b1100, 32'hABCDABCD, 1);
    wait_done();
    issue(1, 3'b000, 32'h41, 32'h000000A5, 0, 0, 32'h00000034, 0, 2, 1, 4'b0010, 32'hA5A5A5A5, 1);
    wait_done();

    // faults before any request: misaligned and illegal sizes
    issue(0, 3'b010, 32'h101, 0, 0, 0, 32'h0, 1, 1, 0, 4'b0, 0, 0);
    wait_done();
    issue(0, 3'b011, 32'h100, 0, 0, 0, 32'h0, 1, 1, 0, 4'b0, 0, 0);
    wait_done();
    issue(0, 3'b001, 32'h103, 0, 0, 0, 32'h0, 1, 1, 0, 4'b0, 0, 0);
    wait_done();
    issue(1, 3'b100, 32'h100, 32'h5, 0, 0, 32'h0, 1, 1, 0, 4'b0, 0, 0);
    wait_done();

    // timeout after a load that leaves rdata nonzero
    issue(0, 3'b010, 32'h104, 0, 0, 32'h55AA55AA, 32'h55AA55AA, 0, 2, 1, 4'b1111, 0, 1);
    wait_done();
    issue(1, 3'b010, 32'h40, 32'h11223344, -1, 0, 32'h0, 1, 5, 1, 4'b1111, 32'h11223344, 4);
    wait_done();
    late_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_busy", {31'd0, busy}, 32'd0);
    end
    late_ack = 1'b0;

    // second start while busy is dropped
    issue(0, 3'b010, 32'h300, 0, 2, 32'h0BADF00D, 32'h0BADF00D, 0, 4, 1, 4'b1111, 0, 3);
    @(negedge clk);
    start  = 1'b1;
    we     = 1'b1;
    funct3 = 3'b010;
    addr   = 32'h400;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // reset in the middle of a request
    issue(0, 3'b010, 32'h200, 0, -1, 0, 32'h0, 0, 99, 1, 4'b1111, 0, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    void'(dq.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 3'b010, 32'h100, 0, 1, 32'hCAFEBABE, 32'hCAFEBABE, 0, 3, 1, 4'b1111, 0, 2);
    wait_done();
    repeat (3) @(negedge clk);
    chk("mem_queue_drained", mq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
